// File: rtl/grayscale_job_scheduler_if.sv
// Host-side channel bundle for the grayscale job scheduler.
// master : scheduler side (drives read/write requests, sees backpressure/results/acks)
// slave  : requestor/host side
//   rd_req_valid/rd_req_addr  - line read request
//   rd_almfull                - c0 Tx almost-full
//   res_valid                 - datapath result line valid (in read order)
//   wr_req_valid/wr_req_addr  - line write request
//   wr_rsp_valid              - one single-line write acknowledged
interface grayscale_job_scheduler_if #(
    parameter int unsigned ADDR_W = 42
);
    logic              rd_req_valid;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_almfull;
    logic              res_valid;
    logic              wr_req_valid;
    logic [ADDR_W-1:0] wr_req_addr;
    logic              wr_rsp_valid;

    modport master (
        output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr,
        input  rd_almfull, res_valid, wr_rsp_valid
    );

    modport slave (
        input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr,
        output rd_almfull, res_valid, wr_rsp_valid
    );
endinterface

// File: rtl/grayscale_job_scheduler.sv
// Grayscale job scheduler: walks the CSR buffer table, issues line reads per
// job and tags in-order datapath results with their write-back address,
// bounding lines in flight between read issue and write ack.
// Ports:
//   clk, reset_n       - clock, async active-low reset
//   start              - pulse: begin a pass (ignored unless idle)
//   buf_valid/src/dst/lines - buffer table (valid sampled at start)
//   host               - read/result/write/ack channel (master side)
//   busy, done, cur_buf - pass status, completion pulse, entry being read
// Optional (macro GRAYSCALE_SCHED_PERF_EN): perf_cycles, perf_stall counters.
module grayscale_job_scheduler #(
    parameter int unsigned NUM_BUF         = 4,
    parameter int unsigned ADDR_W          = 42,
    parameter int unsigned LEN_W           = 32,
    parameter int unsigned MAX_OUTSTANDING = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [NUM_BUF-1:0]          buf_valid,
    input  logic [NUM_BUF*ADDR_W-1:0]   buf_src_addr,
    input  logic [NUM_BUF*ADDR_W-1:0]   buf_dst_addr,
    input  logic [NUM_BUF*LEN_W-1:0]    buf_lines,
    grayscale_job_scheduler_if.master   host,
    output logic                        busy,
    output logic                        done,
    output logic [((NUM_BUF > 1) ? $clog2(NUM_BUF) : 1)-1:0] cur_buf
`ifdef GRAYSCALE_SCHED_PERF_EN
    ,
    output logic [63:0]                 perf_cycles,
    output logic [63:0]                 perf_stall
`endif
);
    localparam int unsigned IDX_W = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_BUF + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_RUN, S_DRAIN, S_FINISH} state_t;

    state_t             state, state_next;
    logic [NUM_BUF-1:0] pending;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [LEN_W-1:0]   rd_left;
    logic [OUT_W-1:0]   outstanding;

    // Job FIFO: one entry per selected job, popped as its last result is written.
    logic [ADDR_W-1:0]  fifo_dst [NUM_BUF];
    logic [LEN_W-1:0]   fifo_len [NUM_BUF];
    logic [IDX_W-1:0]   fifo_wr_idx, fifo_rd_idx;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [LEN_W-1:0]   wr_off;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [NUM_BUF-1:0] sel_mask, zero_mask;
    logic               issue_c, push_c, pop_c, wr_fire_c, rsp_dec_c;
    logic               busy_d, done_d;

    // Lowest pending entry with a non-zero line count; zero-length pending entries flagged.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_mask  = '0;
        zero_mask = '0;
        for (int i = 0; i < int'(NUM_BUF); i++) begin
            if (pending[i]) begin
                if (buf_lines[i*LEN_W +: LEN_W] == '0) begin
                    zero_mask[i] = 1'b1;
                end else if (!sel_found) begin
                    sel_found   = 1'b1;
                    sel_idx     = IDX_W'(i);
                    sel_mask[i] = 1'b1;
                end
            end
        end
    end

    assign issue_c   = (state == S_RUN) && (rd_left != '0) && !host.rd_almfull &&
                       (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign push_c    = (state == S_SELECT) && sel_found;
    assign wr_fire_c = host.res_valid && (fifo_cnt != '0);
    assign pop_c     = wr_fire_c && ((wr_off + LEN_W'(1)) == fifo_len[fifo_rd_idx]);
    assign rsp_dec_c = host.wr_rsp_valid && (outstanding != '0);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state)
            S_IDLE:   if (start) state_next = S_SELECT;
            S_SELECT: state_next = sel_found ? S_RUN : S_DRAIN;
            S_RUN:    if (issue_c && (rd_left == LEN_W'(1))) state_next = S_SELECT;
            S_DRAIN:  if ((outstanding == '0) && (fifo_cnt == '0)) state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        busy_d = (state_next == S_SELECT) || (state_next == S_RUN) || (state_next == S_DRAIN);
        done_d = (state_next == S_FINISH);
    end

    // Read side: pending mask, read pointer, issue strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending           <= '0;
            rd_ptr            <= '0;
            rd_left           <= '0;
            cur_buf           <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            host.rd_req_valid <= 1'b0;
            host.rd_req_addr  <= '0;
        end else begin
            busy              <= busy_d;
            done              <= done_d;
            host.rd_req_valid <= issue_c;
            if ((state == S_IDLE) && start) begin
                pending <= buf_valid;
            end else if (state == S_SELECT) begin
                pending <= pending & ~zero_mask & ~sel_mask;
            end
            if (push_c) begin
                rd_ptr  <= buf_src_addr[sel_idx*ADDR_W +: ADDR_W];
                rd_left <= buf_lines[sel_idx*LEN_W +: LEN_W];
                cur_buf <= sel_idx;
            end else if (issue_c) begin
                host.rd_req_addr <= rd_ptr;
                rd_ptr           <= rd_ptr + ADDR_W'(1);
                rd_left          <= rd_left - LEN_W'(1);
            end
        end
    end

    // Lines in flight: +1 per read issue, -1 per write ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else begin
            case ({issue_c, rsp_dec_c})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Job FIFO and write tagging; results with no job queued are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_BUF); i++) begin
                fifo_dst[i] <= '0;
                fifo_len[i] <= '0;
            end
            fifo_wr_idx       <= '0;
            fifo_rd_idx       <= '0;
            fifo_cnt          <= '0;
            wr_off            <= '0;
            host.wr_req_valid <= 1'b0;
            host.wr_req_addr  <= '0;
        end else begin
            host.wr_req_valid <= wr_fire_c;
            if (push_c) begin
                fifo_dst[fifo_wr_idx] <= buf_dst_addr[sel_idx*ADDR_W +: ADDR_W];
                fifo_len[fifo_wr_idx] <= buf_lines[sel_idx*LEN_W +: LEN_W];
                fifo_wr_idx <= (fifo_wr_idx == IDX_W'(NUM_BUF - 1)) ? '0 : fifo_wr_idx + IDX_W'(1);
            end
            if (wr_fire_c) begin
                host.wr_req_addr <= fifo_dst[fifo_rd_idx] + ADDR_W'(wr_off);
                wr_off           <= pop_c ? '0 : wr_off + LEN_W'(1);
            end
            if (pop_c) begin
                fifo_rd_idx <= (fifo_rd_idx == IDX_W'(NUM_BUF - 1)) ? '0 : fifo_rd_idx + IDX_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef GRAYSCALE_SCHED_PERF_EN
    logic stall_c;
    assign stall_c = (state == S_RUN) && (rd_left != '0) && !issue_c;

    // Busy and read-stall cycle counters, cleared by an accepted start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if ((state == S_IDLE) && start) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy)    perf_cycles <= perf_cycles + 64'(1);
            if (stall_c) perf_stall  <= perf_stall + 64'(1);
        end
    end
`endif
endmodule

// File: tb/tb_grayscale_job_scheduler.sv
// Scoreboard bench for grayscale_job_scheduler: expected read/write addresses
// are queued when a pass is launched and popped as the DUT issues requests.
module tb_grayscale_job_scheduler;
    localparam int unsigned NB = 4;
    localparam int unsigned AW = 42;
    localparam int unsigned LW = 32;
    localparam int unsigned MO = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [NB-1:0]     buf_valid;
    logic [NB*AW-1:0]  buf_src_addr;
    logic [NB*AW-1:0]  buf_dst_addr;
    logic [NB*LW-1:0]  buf_lines;
    logic              busy, done;
    logic [1:0]        cur_buf;
`ifdef GRAYSCALE_SCHED_PERF_EN
    logic [63:0]       perf_cycles, perf_stall;
`endif

    grayscale_job_scheduler_if #(.ADDR_W(AW)) host_if ();

    grayscale_job_scheduler #(
        .NUM_BUF(NB), .ADDR_W(AW), .LEN_W(LW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .buf_valid(buf_valid),
        .buf_src_addr(buf_src_addr), .buf_dst_addr(buf_dst_addr), .buf_lines(buf_lines),
        .host(host_if), .busy(busy), .done(done), .cur_buf(cur_buf)
`ifdef GRAYSCALE_SCHED_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, inflight = 0;
    int pending_acks = 0, release_req = 0, win_rds = 0;
    bit hold_ack = 0, win_active = 0;

    logic [AW-1:0] exp_rd_q[$];
    logic [AW-1:0] exp_wr_q[$];
    logic [1:0]    exp_buf_q[$];

    logic [AW-1:0] t_src [NB];
    logic [AW-1:0] t_dst [NB];
    logic [LW-1:0] t_len [NB];
    logic [NB-1:0] t_valid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive the table and queue the expected request streams in entry order.
    task automatic launch();
        buf_valid = t_valid;
        for (int i = 0; i < int'(NB); i++) begin
            buf_src_addr[i*AW +: AW] = t_src[i];
            buf_dst_addr[i*AW +: AW] = t_dst[i];
            buf_lines[i*LW +: LW]    = t_len[i];
        end
        for (int i = 0; i < int'(NB); i++) begin
            if (t_valid[i] && (t_len[i] != '0)) begin
                for (int j = 0; j < int'(t_len[i]); j++) begin
                    exp_rd_q.push_back(t_src[i] + AW'(j));
                    exp_buf_q.push_back(2'(i));
                    exp_wr_q.push_back(t_dst[i] + AW'(j));
                end
            end
        end
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    // Wait for one done pulse within a cycle budget, then confirm the pass is fully retired.
    task automatic finish_pass(input string tag, input int budget, input int d0,
                               input int r0, input int w0, input int nlines);
        int n = 0;
        while ((done_cnt == d0) && (n < budget)) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        #3;
        check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
        check({tag, "_reads"}, 64'(rd_cnt - r0), 64'(nlines));
        check({tag, "_writes"}, 64'(wr_cnt - w0), 64'(nlines));
        check({tag, "_rdq_empty"}, 64'(exp_rd_q.size()), 64'd0);
        check({tag, "_wrq_empty"}, 64'(exp_wr_q.size()), 64'd0);
    endtask

    // Host model and monitor: echo results after reads, acks after writes, check streams.
    initial begin
        logic [3:0] res_pipe;
        logic [1:0] ack_pipe;
        bit         ack_prev;
        bit         give;
        res_pipe = '0;
        ack_pipe = '0;
        ack_prev = 1'b0;
        host_if.res_valid    = 1'b0;
        host_if.wr_rsp_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                res_pipe = '0; ack_pipe = '0; ack_prev = 1'b0;
                inflight = 0; pending_acks = 0;
                host_if.res_valid    = 1'b0;
                host_if.wr_rsp_valid = 1'b0;
                continue;
            end
            if (ack_prev) inflight--;
            if (host_if.rd_req_valid) begin
                rd_cnt++;
                inflight++;
                if (win_active) win_rds++;
                check("rd_inflight_le_max", 64'(inflight <= int'(MO)), 64'd1);
                check("rd_expected", 64'(exp_rd_q.size() != 0), 64'd1);
                if (exp_rd_q.size() != 0) begin
                    check("rd_addr", 64'(host_if.rd_req_addr), 64'(exp_rd_q.pop_front()));
                    check("rd_cur_buf", 64'(cur_buf), 64'(exp_buf_q.pop_front()));
                end
            end
            if (host_if.wr_req_valid) begin
                wr_cnt++;
                check("wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
                if (exp_wr_q.size() != 0)
                    check("wr_addr", 64'(host_if.wr_req_addr), 64'(exp_wr_q.pop_front()));
            end
            if (done) begin
                done_cnt++;
                check("busy_at_done", 64'(busy), 64'd0);
            end
            res_pipe = {res_pipe[2:0], host_if.rd_req_valid};
            host_if.res_valid = res_pipe[3];
            ack_pipe = {ack_pipe[0], host_if.wr_req_valid};
            if (ack_pipe[1]) pending_acks++;
            give = (pending_acks > 0) && (!hold_ack || (release_req > 0));
            if (give) begin
                pending_acks--;
                if (hold_ack) release_req--;
            end
            host_if.wr_rsp_valid = give;
            ack_prev = give;
        end
    end

    initial begin
        int d0, r0, w0, n;
`ifdef GRAYSCALE_SCHED_PERF_EN
        logic [63:0] s_mid;
`endif
        reset_n = 1'b0; start = 1'b0; buf_valid = '0;
        buf_src_addr = '0; buf_dst_addr = '0; buf_lines = '0;
        host_if.rd_almfull = 1'b0;
        for (int i = 0; i < int'(NB); i++) begin
            t_src[i] = AW'(32'h1000 * (i + 1));
            t_dst[i] = AW'(32'h8000 + 32'h1000 * i);
            t_len[i] = LW'(7);
        end
        repeat (3) @(posedge clk);
        #3;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_valid", 64'(host_if.rd_req_valid), 64'd0);
        check("rst_wr_valid", 64'(host_if.wr_req_valid), 64'd0);
        check("rst_cur_buf", 64'(cur_buf), 64'd0);
        @(negedge clk) reset_n = 1'b1;

        // Single job.
        t_valid = 4'b0001; t_src[0] = AW'(32'h100); t_dst[0] = AW'(32'h200); t_len[0] = LW'(3);
        d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
        launch();
        finish_pass("single", 300, d0, r0, w0, 3);

        // Multi job with a zero-length entry and an ignored start mid-pass.
        t_valid = 4'b1011;
        t_src[0] = AW'(32'h1000); t_len[0] = LW'(5);
        t_len[1] = LW'(0);
        t_len[2] = LW'(2);
        t_src[3] = AW'(32'h4000); t_len[3] = LW'(4);
        d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
        launch();
        repeat (8) @(posedge clk);
        #2 buf_valid = 4'b0100;
        pulse_start();
        finish_pass("multi", 400, d0, r0, w0, 9);

        // Throttle at the outstanding limit, including a simultaneous issue and ack.
        hold_ack = 1;
        t_valid = 4'b0001; t_src[0] = AW'(32'h3000); t_dst[0] = AW'(32'h5000); t_len[0] = LW'(10);
        d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
        launch();
        repeat (15) @(posedge clk);
`ifdef GRAYSCALE_SCHED_PERF_EN
        s_mid = perf_stall;
`endif
        repeat (15) @(posedge clk);
        #3 check("thr_hold_reads", 64'(rd_cnt - r0), 64'(MO));
`ifdef GRAYSCALE_SCHED_PERF_EN
        check("perf_stall_grows", 64'(perf_stall > s_mid), 64'd1);
`endif
        release_req = 1;
        repeat (20) @(posedge clk);
        #3 check("thr_one_ack_reads", 64'(rd_cnt - r0), 64'(MO + 1));
        release_req = 2;
        repeat (20) @(posedge clk);
        #3 check("thr_simul_reads", 64'(rd_cnt - r0), 64'(MO + 3));
        hold_ack = 0; release_req = 0;
        finish_pass("throttle", 400, d0, r0, w0, 10);
`ifdef GRAYSCALE_SCHED_PERF_EN
        s_mid = perf_cycles;
        repeat (5) @(posedge clk);
        #3 check("perf_cycles_hold", perf_cycles, s_mid);
`endif

        // Backpressure window mid-job.
        t_valid = 4'b0001; t_src[0] = AW'(32'h6000); t_dst[0] = AW'(32'h7000); t_len[0] = LW'(12);
        d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
        launch();
        n = 0;
        while ((rd_cnt - r0 < 3) && (n < 100)) begin
            @(posedge clk);
            n++;
        end
        check("bp_reached_window", 64'(rd_cnt - r0 >= 3), 64'd1);
        @(posedge clk);
        #2 host_if.rd_almfull = 1'b1; win_active = 1; win_rds = 0;
        repeat (10) @(posedge clk);
        #2 host_if.rd_almfull = 1'b0; win_active = 0;
        check("bp_no_reads", 64'(win_rds), 64'd0);
        finish_pass("backpressure", 400, d0, r0, w0, 12);

        // Reset in the middle of RUN, then a clean pass.
        hold_ack = 1;
        t_valid = 4'b0001; t_src[0] = AW'(32'h9000); t_dst[0] = AW'(32'hA000); t_len[0] = LW'(20);
        d0 = done_cnt;
        launch();
        repeat (12) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_rd_valid", 64'(host_if.rd_req_valid), 64'd0);
        check("mid_rst_rd_addr", 64'(host_if.rd_req_addr), 64'd0);
        check("mid_rst_wr_valid", 64'(host_if.wr_req_valid), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        exp_rd_q.delete(); exp_wr_q.delete(); exp_buf_q.delete();
        hold_ack = 0; release_req = 0;
        repeat (3) @(posedge clk);
        #3 check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        @(negedge clk) reset_n = 1'b1;
        t_valid = 4'b0011;
        t_src[0] = AW'(32'hB000); t_dst[0] = AW'(32'hC000); t_len[0] = LW'(2);
        t_src[1] = AW'(32'hD000); t_dst[1] = AW'(32'hE000); t_len[1] = LW'(3);
        d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
        launch();
        finish_pass("after_rst", 400, d0, r0, w0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
